// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM port between IF fetches and MEM loads/stores.
// Define ARB_FAIR_EN for round-robin tie-breaking; otherwise MEM always beats IF.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_cancel_in,
  output logic              if_done_out,
  output logic [XLEN-1:0]   if_data_out,
  output logic              if_busy_out,
  input  logic              mem_req_in,
  input  logic              mem_wr_in,
  input  logic [1:0]        mem_len_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [XLEN-1:0]   mem_wdata_in,
  output logic              mem_done_out,
  output logic [XLEN-1:0]   mem_rdata_out,
  output logic              mem_busy_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out
);
  localparam int NB = XLEN / 8;
  localparam int CW = $clog2(NB + 2);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cyc, cyc_nx, n_q, n_nx, bi;
  logic own_mem, own_nx, wr_q, wr_nx, stl, stl_nx;
  logic [ADDR_W-1:0] base, base_nx, ram_a_nx;
  logic [XLEN-1:0] wd_q, wd_nx, acc, acc_nx, if_data_nx, mem_rdata_nx;
  logic [7:0] ram_dout_nx;
  logic ram_wr_q, ram_wr_nx, if_done_nx, mem_done_nx;
  logic if_ok, gnt_mem, gnt_if, cap, fin, abort;
`ifdef ARB_FAIR_EN
  logic last_mem, last_nx;
`endif
  assign if_ok = if_req_in & ~if_cancel_in;
`ifdef ARB_FAIR_EN
  assign gnt_mem = mem_req_in & (~if_ok | ~last_mem);
`else
  assign gnt_mem = mem_req_in;
`endif
  assign gnt_if = if_ok & ~gnt_mem;
  assign bi = cyc - CW'(2);
  // The byte in flight when rdy drops is caught on the first stalled edge; the held address is re-read on resume.
  assign cap = state == BUSY & ~wr_q & cyc >= CW'(2) & ~stl;
  assign fin = wr_q ? cyc == n_q : cyc == n_q + CW'(1);
  assign abort = ~own_mem & if_cancel_in;
  assign ram_wr_out = ram_wr_q & rdy_in;
  assign if_busy_out = (if_req_in & ~if_done_out) | (state == BUSY & ~own_mem);
  assign mem_busy_out = (mem_req_in & ~mem_done_out) | (state == BUSY & own_mem);
  always_comb begin
    state_nx = state;
    cyc_nx = cyc;
    n_nx = n_q;
    own_nx = own_mem;
    wr_nx = wr_q;
    base_nx = base;
    wd_nx = wd_q;
    acc_nx = acc;
    stl_nx = 1'b1;
    ram_a_nx = ram_a_out;
    ram_dout_nx = ram_dout_out;
    ram_wr_nx = ram_wr_q;
    if_done_nx = 1'b0;
    mem_done_nx = 1'b0;
    if_data_nx = if_data_out;
    mem_rdata_nx = mem_rdata_out;
`ifdef ARB_FAIR_EN
    last_nx = last_mem;
`endif
    for (int i = 0; i < NB; i++)
      if (cap && bi == CW'(i)) acc_nx[8*i +: 8] = ram_din_in;
    if (rdy_in) begin
      stl_nx = 1'b0;
      if (state == IDLE) begin
        if (gnt_mem | gnt_if) begin
          state_nx = BUSY;
          cyc_nx = CW'(1);
          own_nx = gnt_mem;
          wr_nx = gnt_mem & mem_wr_in;
          n_nx = ~gnt_mem ? CW'(NB) : mem_len_in == 2'd0 ? CW'(1) : mem_len_in == 2'd1 ? CW'(2) : CW'(NB);
          base_nx = gnt_mem ? mem_addr_in : if_addr_in;
          wd_nx = gnt_mem ? mem_wdata_in : '0;
          acc_nx = '0;
          ram_a_nx = base_nx;
          ram_dout_nx = wd_nx[7:0];
          ram_wr_nx = wr_nx;
`ifdef ARB_FAIR_EN
          last_nx = gnt_mem;
`endif
        end
      end else if (fin | abort) begin
        state_nx = IDLE;
        cyc_nx = '0;
        ram_wr_nx = 1'b0;
        if_done_nx = ~own_mem & ~abort;
        mem_done_nx = own_mem;
        if_data_nx = if_done_nx ? acc_nx : if_data_out;
        mem_rdata_nx = own_mem & ~wr_q ? acc_nx : mem_rdata_out;
      end else begin
        cyc_nx = cyc + CW'(1);
        ram_wr_nx = wr_q & (cyc < n_q);
        if (cyc < n_q) begin
          ram_a_nx = base + ADDR_W'(cyc);
          ram_dout_nx = 8'(wd_q >> (8 * cyc));
        end
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cyc <= '0;
      n_q <= '0;
      own_mem <= 1'b0;
      wr_q <= 1'b0;
      base <= '0;
      wd_q <= '0;
      acc <= '0;
      stl <= 1'b0;
      ram_a_out <= '0;
      ram_dout_out <= '0;
      ram_wr_q <= 1'b0;
      if_done_out <= 1'b0;
      mem_done_out <= 1'b0;
      if_data_out <= '0;
      mem_rdata_out <= '0;
`ifdef ARB_FAIR_EN
      last_mem <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cyc <= cyc_nx;
      n_q <= n_nx;
      own_mem <= own_nx;
      wr_q <= wr_nx;
      base <= base_nx;
      wd_q <= wd_nx;
      acc <= acc_nx;
      stl <= stl_nx;
      ram_a_out <= ram_a_nx;
      ram_dout_out <= ram_dout_nx;
      ram_wr_q <= ram_wr_nx;
      if_done_out <= if_done_nx;
      mem_done_out <= mem_done_nx;
      if_data_out <= if_data_nx;
      mem_rdata_out <= mem_rdata_nx;
`ifdef ARB_FAIR_EN
      last_mem <= last_nx;
`endif
    end
  end
endmodule
